perf_counter_bank: RTL and testbench
====================================

# perf_counter_bank

Synthesizable bank of per-event performance counters that accumulates single-cycle event strobes from the pipeline and caches (I/D-cache hit and request, register write, memory write, halt). It also keeps a free-running cycle counter. It sits beside `cpu`, taps its internal strobes, and freezes on `hlt`. Software or the bench reads a coherent snapshot through a registered select port. Counter width, channel count and overflow mode are all parameters.

## Interface
- `NUM_CH`, 8: number of event channels (1..16).
- `CNT_W`, 32: width of every counter, including the cycle counter (8..32).
- `SAT`, 0: overflow mode. 0 means wrap to zero; 1 means saturate at all-ones.
- `SEL_W`, `$clog2(NUM_CH)` (minimum 1): width of the read select.

Ports:
- `clk`, in, 1: clock.
- `rst_n`, in, 1: reset. Synchronous, active-low.
- `ev_i`, in, `NUM_CH`: event strobes. Bit *k* high means one event on channel *k* this cycle.
- `en_i`, in, 1: global count enable.
- `halt_i`, in, 1: processor halt. Freezes the bank after the current cycle.
- `clr_i`, in, 1: synchronous clear of counters, overflow flags and freeze.
- `snap_i`, in, 1: copy all live counters into the shadow registers.
- `rd_sel_i`, in, `SEL_W`: shadow channel to read. Index `NUM_CH` selects the cycle counter shadow, if it is representable in `SEL_W`.
- `rd_data_o`, out, `CNT_W`: registered shadow value.
- `rd_valid_o`, out, 1: `rd_data_o` corresponds to the `rd_sel_i` from the previous cycle.
- `ovf_o`, out, `NUM_CH`: sticky per-channel overflow flags.
- `cyc_o`, out, `CNT_W`: live cycle counter.
- `frozen_o`, out, 1: the bank is frozen.

## Operation
- **Count condition:** `active = en_i & ~frozen_o`.
- **Event counters:** channel *k* adds 1 when `active & ev_i[k]`.
- **Cycle counter:** `cyc_o` adds 1 on every cycle where `active` is true.
- **Halt:**
  - In a cycle with `halt_i=1`, events in that same cycle still count.
  - `frozen_o` is 1 from the next cycle.
  - The freeze is held until `clr_i` or reset; `halt_i` falling does not release it.
- **Overflow:** applies to the event counters only, when a counter is at `2^CNT_W-1` and increments.
  - `SAT=0`: the counter goes to 0 and `ovf_o[k]` is set.
  - `SAT=1`: the counter stays at all-ones and `ovf_o[k]` is set.
  - `cyc_o` always wraps and has no flag.
- **Clear (`clr_i`):** counters, `cyc_o`, `ovf_o` and `frozen_o` go to 0 next cycle.
  - Clear has priority over increment and over `halt_i` in the same cycle.
  - Shadows are not cleared.
- **Snapshot (`snap_i`):** every shadow takes the live counter value *before* this cycle's update.
  - With `snap_i` and `clr_i` together, the shadows receive the pre-clear values.
- **Read:**
  - `rd_data_o <= shadow[rd_sel_i]` each cycle.
  - Any `rd_sel_i` greater than `NUM_CH` returns 0 with `rd_valid_o=1`.

## Timing
- **Reset:** all counters, shadows, `ovf_o`, `frozen_o`, `rd_data_o`, `rd_valid_o` and `cyc_o` are 0.
- **Counter latency:** an event at cycle *n* is visible in the live counter at *n+1*.
- **Read latency:**
  - Snapshot at *n* → shadow updated at *n+1*.
  - `rd_sel_i` at *n+1* → `rd_data_o` at *n+2*.
- **`rd_valid_o`:** 0 in the first cycle after reset release, 1 on every cycle after that.
- **Reset mid-count:** everything returns to reset values on the edge; no partial state survives.
- **Throughput:** one increment per channel per cycle. All channels are independent and may fire together.

## Structure
- **Package `perf_pkg`:**
  - `OVF_WRAP`/`OVF_SAT` mode constants.
  - `clog2` helper function.
  - Standard channel index constants: `CH_ICACHE_HIT=0`, `CH_DCACHE_HIT=1`, `CH_ICACHE_REQ=2`, `CH_DCACHE_REQ=3`, `CH_REGWRITE=4`, `CH_MEMWRITE=5`, `CH_HALT=6`, `CH_STALL=7`.
- **Sub-module `perf_ctr`:** a single counter with its overflow flag (`CNT_W`, `SAT`), instantiated `NUM_CH` times with a generate loop.
- **Top level:** freeze logic, cycle counter, shadow array and read mux.

## Test plan
1. Reset, then `en_i=1` and `ev_i=8'h01` for 10 cycles, then snap and read sel 0 → `rd_data_o=10`. Read sel 8 → cycle count ≥ 10; `ovf_o=0`.
2. `CNT_W=8`, `SAT=0`, 257 events on channel 3 → counter reads 1 and `ovf_o[3]=1`. Repeat with `SAT=1` → counter reads 255 and the flag is set.
3. Events on channels 1 and 2 every cycle, with `halt_i` pulsed high on cycle 5 → both counters read 6 and `frozen_o=1`. Further events leave the counts at 6.
4. `clr_i` and `snap_i` together with counter 0 at 42 → shadow 0 reads 42, live counter 0 is 0, `frozen_o=0`.
5. `en_i=0` with all `ev_i` high for 20 cycles → all counters and `cyc_o` unchanged.
6. Assert `rst_n=0` for one cycle during counting → all outputs 0 on the next cycle. `rd_sel_i=15` with `NUM_CH=8` returns 0.

Source files
------------

// File: rtl/perf_counter_bank_pkg.sv
// Shared constants for the performance counter bank:
// overflow modes, channel map and a width helper.
package perf_pkg;

  localparam int OVF_WRAP = 0;
  localparam int OVF_SAT  = 1;

  localparam int CH_ICACHE_HIT = 0;
  localparam int CH_DCACHE_HIT = 1;
  localparam int CH_ICACHE_REQ = 2;
  localparam int CH_DCACHE_REQ = 3;
  localparam int CH_REGWRITE   = 4;
  localparam int CH_MEMWRITE   = 5;
  localparam int CH_HALT       = 6;
  localparam int CH_STALL      = 7;

  // ceil(log2(n)), never below 1 so selects keep a real bit
  function automatic int clog2(input int n);
    int r;
    r = 1;
    for (int i = 1; i < 31; i++)
      if ((1 << i) < n) r = i + 1;
    return r;
  endfunction

endpackage

// File: rtl/perf_counter_bank_if.sv
// Control, event and read-port bundle between a host
// (pipeline tap / software) and the counter bank.
interface perf_counter_bank_if
  import perf_pkg::*;
#(
  parameter int NUM_CH = 8,
  parameter int CNT_W  = 32,
  parameter int SEL_W  = clog2(NUM_CH)
);
  logic [NUM_CH-1:0] ev_i;
  logic              en_i;
  logic              halt_i;
  logic              clr_i;
  logic              snap_i;
  logic [SEL_W-1:0]  rd_sel_i;
  logic [CNT_W-1:0]  rd_data_o;
  logic              rd_valid_o;
  logic [NUM_CH-1:0] ovf_o;
  logic [CNT_W-1:0]  cyc_o;
  logic              frozen_o;

  modport master (
    output ev_i, en_i, halt_i, clr_i, snap_i,
    output rd_sel_i,
    input  rd_data_o, rd_valid_o, ovf_o,
    input  cyc_o, frozen_o
  );

  modport slave (
    input  ev_i, en_i, halt_i, clr_i, snap_i,
    input  rd_sel_i,
    output rd_data_o, rd_valid_o, ovf_o,
    output cyc_o, frozen_o
  );
endinterface

// File: rtl/perf_counter_bank_ctr.sv
// One event counter with a sticky overflow flag;
// wraps or saturates at all-ones.
module perf_ctr
  import perf_pkg::*;
#(
  parameter int CNT_W = 32,
  parameter int SAT   = OVF_WRAP
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt,
  output logic             ovf
);
  localparam logic [CNT_W-1:0] MAX = '1;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
      ovf <= 1'b0;
    end else if (clr) begin
      cnt <= '0;
      ovf <= 1'b0;
    end else if (inc) begin
      if (cnt == MAX) begin
        ovf <= 1'b1;
        if (SAT == OVF_WRAP) cnt <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end
endmodule

// File: rtl/perf_counter_bank.sv
// Event counter bank: freeze on halt, cycle counter,
// snapshot shadows and a registered read mux.
module perf_counter_bank
  import perf_pkg::*;
#(
  parameter int NUM_CH = 8,
  parameter int CNT_W  = 32,
  parameter int SAT    = OVF_WRAP,
  parameter int SEL_W  = clog2(NUM_CH)
) (
  input logic               clk,
  input logic               rst_n,
  perf_counter_bank_if.slave bus
);
  logic [CNT_W-1:0]  cnt [NUM_CH];
  logic [CNT_W-1:0]  shadow [NUM_CH+1];
  logic [NUM_CH-1:0] ovf;
  logic [CNT_W-1:0]  cyc;
  logic [CNT_W-1:0]  rd_next;
  logic [CNT_W-1:0]  rd_data;
  logic              rd_valid;
  logic              frozen;
  logic              active;

  assign active = bus.en_i & ~frozen;

  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    perf_ctr #(
      .CNT_W(CNT_W),
      .SAT  (SAT)
    ) u_ctr (
      .clk  (clk),
      .rst_n(rst_n),
      .clr  (bus.clr_i),
      .inc  (active & bus.ev_i[k]),
      .cnt  (cnt[k]),
      .ovf  (ovf[k])
    );
  end

  // halt freezes from the next cycle; only clear unfreezes
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      frozen <= 1'b0;
      cyc    <= '0;
    end else if (bus.clr_i) begin
      frozen <= 1'b0;
      cyc    <= '0;
    end else begin
      if (active) cyc <= cyc + 1'b1;
      if (bus.halt_i) frozen <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i <= NUM_CH; i++)
        shadow[i] <= '0;
    end else if (bus.snap_i) begin
      for (int i = 0; i < NUM_CH; i++)
        shadow[i] <= cnt[i];
      shadow[NUM_CH] <= cyc;
    end
  end

  always_comb begin
    rd_next = '0;
    for (int i = 0; i <= NUM_CH; i++)
      if (32'(bus.rd_sel_i) == i)
        rd_next = shadow[i];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_data  <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_data  <= rd_next;
      rd_valid <= 1'b1;
    end
  end

  assign bus.rd_data_o  = rd_data;
  assign bus.rd_valid_o = rd_valid;
  assign bus.ovf_o      = ovf;
  assign bus.cyc_o      = cyc;
  assign bus.frozen_o   = frozen;
endmodule

// File: tb/tb_perf_counter_bank.sv
// Randomized scoreboard bench: a wrapping and a
// saturating 8-bit bank share stimulus and one model.
module tb_perf_counter_bank;
  import perf_pkg::*;

  localparam int NCH = 8;
  localparam int W   = 8;
  localparam int SW  = 4;
  localparam int MOD = 1 << W;

  logic           clk;
  logic           rst_n;
  logic [NCH-1:0] ev;
  logic           en, halt, clr, snap;
  logic [SW-1:0]  sel;

  perf_counter_bank_if #(NCH, W, SW) bw ();
  perf_counter_bank_if #(NCH, W, SW) bs ();

  assign bw.ev_i = ev;
  assign bw.en_i = en;
  assign bw.halt_i = halt;
  assign bw.clr_i = clr;
  assign bw.snap_i = snap;
  assign bw.rd_sel_i = sel;
  assign bs.ev_i = ev;
  assign bs.en_i = en;
  assign bs.halt_i = halt;
  assign bs.clr_i = clr;
  assign bs.snap_i = snap;
  assign bs.rd_sel_i = sel;

  perf_counter_bank #(
    .NUM_CH(NCH), .CNT_W(W),
    .SAT(OVF_WRAP), .SEL_W(SW)
  ) dut_w (.clk(clk), .rst_n(rst_n), .bus(bw));

  perf_counter_bank #(
    .NUM_CH(NCH), .CNT_W(W),
    .SAT(OVF_SAT), .SEL_W(SW)
  ) dut_s (.clk(clk), .rst_n(rst_n), .bus(bs));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct packed {
    logic [7:0] rd0, rd1;
    logic       vld;
    logic [7:0] ov0, ov1;
    logic [7:0] cyc;
    logic       frz;
  } exp_t;

  exp_t q[$];
  int   ntot = 0;
  int   npass = 0;

  int   mcnt [2][NCH];
  bit   movf [2][NCH];
  int   msh  [2][NCH+1];
  int   mrd  [2];
  int   mcyc;
  bit   mfrz;
  bit   mvld;

  task automatic chk(input string nm,
                     input int act, input int req);
    ntot++;
    if (act == req) npass++;
    else $display("FAIL %s: got %0d want %0d",
                  nm, act, req);
  endtask

  function automatic logic [7:0] ovf_vec(input int d);
    logic [7:0] v;
    for (int k = 0; k < NCH; k++) v[k] = movf[d][k];
    return v;
  endfunction

  // counts as plain integers modulo 2^W
  task automatic model_step();
    bit act;
    if (!rst_n) begin
      for (int d = 0; d < 2; d++) begin
        mrd[d] = 0;
        for (int k = 0; k < NCH; k++) begin
          mcnt[d][k] = 0;
          movf[d][k] = 0;
        end
        for (int k = 0; k <= NCH; k++) msh[d][k] = 0;
      end
      mcyc = 0;
      mfrz = 0;
      mvld = 0;
      return;
    end
    act = en && !mfrz;
    for (int d = 0; d < 2; d++) begin
      mrd[d] = (int'(sel) <= NCH) ? msh[d][sel] : 0;
      if (snap) begin
        for (int k = 0; k < NCH; k++)
          msh[d][k] = mcnt[d][k];
        msh[d][NCH] = mcyc;
      end
      for (int k = 0; k < NCH; k++) begin
        if (clr) begin
          mcnt[d][k] = 0;
          movf[d][k] = 0;
        end else if (act && ev[k]) begin
          if (mcnt[d][k] == MOD - 1) begin
            movf[d][k] = 1;
            mcnt[d][k] = (d == 1) ? MOD - 1 : 0;
          end else begin
            mcnt[d][k]++;
          end
        end
      end
    end
    if (clr) begin
      mcyc = 0;
      mfrz = 0;
    end else begin
      if (act) mcyc = (mcyc + 1) % MOD;
      if (halt) mfrz = 1;
    end
    mvld = 1;
  endtask

  task automatic cycle(input logic r,
                       input logic [NCH-1:0] e,
                       input logic n, h, c, s,
                       input logic [SW-1:0] sl);
    exp_t x;
    rst_n = r;
    ev = e;
    en = n;
    halt = h;
    clr = c;
    snap = s;
    sel = sl;
    model_step();
    x.rd0 = 8'(mrd[0]);
    x.rd1 = 8'(mrd[1]);
    x.vld = mvld;
    x.ov0 = ovf_vec(0);
    x.ov1 = ovf_vec(1);
    x.cyc = 8'(mcyc);
    x.frz = mfrz;
    @(posedge clk);
    #1;
    q.push_back(x);
  endtask

  task automatic idle(input logic [SW-1:0] sl);
    cycle(1, 0, 1, 0, 0, 0, sl);
  endtask

  initial begin : monitor
    exp_t x;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        x = q.pop_front();
        chk("rd_valid", int'(bw.rd_valid_o), int'(x.vld));
        chk("rd_valid_s", int'(bs.rd_valid_o), int'(x.vld));
        chk("rd_data_w", int'(bw.rd_data_o), int'(x.rd0));
        chk("rd_data_s", int'(bs.rd_data_o), int'(x.rd1));
        chk("ovf_w", int'(bw.ovf_o), int'(x.ov0));
        chk("ovf_s", int'(bs.ovf_o), int'(x.ov1));
        chk("cyc_w", int'(bw.cyc_o), int'(x.cyc));
        chk("cyc_s", int'(bs.cyc_o), int'(x.cyc));
        chk("frozen_w", int'(bw.frozen_o), int'(x.frz));
        chk("frozen_s", int'(bs.frozen_o), int'(x.frz));
      end
    end
  end

  initial begin : stim
    int hold;
    rst_n = 1'b0;
    ev = '0;
    en = 1'b0;
    halt = 1'b0;
    clr = 1'b0;
    snap = 1'b0;
    sel = '0;
    cycle(0, 0, 0, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0, 0, 0);
    chk("reset_valid", int'(bw.rd_valid_o), 0);
    chk("reset_cyc", int'(bw.cyc_o), 0);

    // ten events on the icache-hit channel
    for (int i = 0; i < 10; i++)
      cycle(1, 8'(1 << CH_ICACHE_HIT), 1, 0, 0, 0, 0);
    cycle(1, 0, 1, 0, 0, 1, 0);
    idle(0);
    chk("t1_sel0", int'(bw.rd_data_o), 10);
    idle(8);
    chk("t1_cyc_ge10", int'(bw.rd_data_o >= 10), 1);
    chk("t1_ovf", int'(bw.ovf_o), 0);

    // 257 events on channel 3: wrap vs saturate
    cycle(1, 0, 1, 0, 1, 0, 0);
    for (int i = 0; i < 257; i++)
      cycle(1, 8'(1 << CH_DCACHE_REQ), 1, 0, 0, 0, 0);
    cycle(1, 0, 1, 0, 0, 1, 0);
    idle(3);
    chk("t2_wrap", int'(bw.rd_data_o), 1);
    chk("t2_sat", int'(bs.rd_data_o), 255);
    chk("t2_ovf_w", int'(bw.ovf_o[3]), 1);
    chk("t2_ovf_s", int'(bs.ovf_o[3]), 1);

    // halt on the sixth cycle freezes both channels at 6
    cycle(1, 0, 1, 0, 1, 0, 0);
    for (int i = 0; i < 11; i++)
      cycle(1, 8'h06, 1, 1'(i == 5), 0, 0, 0);
    cycle(1, 0, 1, 0, 0, 1, 0);
    idle(1);
    chk("t3_ch1", int'(bw.rd_data_o), 6);
    idle(2);
    chk("t3_ch2", int'(bw.rd_data_o), 6);
    chk("t3_frozen", int'(bw.frozen_o), 1);

    // clear and snapshot together keep pre-clear values
    cycle(1, 0, 1, 0, 1, 0, 0);
    for (int i = 0; i < 42; i++)
      cycle(1, 8'h01, 1, 0, 0, 0, 0);
    cycle(1, 0, 1, 0, 1, 1, 0);
    idle(0);
    chk("t4_shadow", int'(bw.rd_data_o), 42);
    chk("t4_frozen", int'(bw.frozen_o), 0);
    cycle(1, 0, 1, 0, 0, 1, 0);
    idle(0);
    chk("t4_live", int'(bw.rd_data_o), 0);

    // disabled bank ignores everything
    hold = mcyc;
    for (int i = 0; i < 20; i++)
      cycle(1, 8'hff, 0, 0, 0, 0, 0);
    chk("t5_cyc", int'(bw.cyc_o), hold);

    for (int i = 0; i < 3000; i++) begin
      cycle(($urandom_range(0, 499) != 0),
            8'($urandom),
            ($urandom_range(0, 7) != 0),
            ($urandom_range(0, 199) == 0),
            ($urandom_range(0, 299) == 0),
            ($urandom_range(0, 7) == 0),
            4'($urandom));
    end

    // reset while counting
    for (int i = 0; i < 5; i++)
      cycle(1, 8'hff, 1, 0, 0, 1, 0);
    cycle(0, 8'hff, 1, 0, 0, 0, 0);
    chk("t6_valid", int'(bw.rd_valid_o), 0);
    chk("t6_cyc", int'(bw.cyc_o), 0);
    chk("t6_ovf", int'(bs.ovf_o), 0);
    for (int i = 0; i < 4; i++)
      cycle(1, 8'hff, 1, 0, 0, 1, 0);
    idle(15);
    chk("t6_sel15", int'(bw.rd_data_o), 0);
    idle(9);
    chk("t6_sel9", int'(bw.rd_data_o), 0);

    repeat (3) @(negedge clk);
    chk("drain", q.size(), 0);
    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end
endmodule
